// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word req/ack reads to
// instruction memory and presents each word downstream with a valid/stall handshake.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [15:0] branch_addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    output logic [15:0] pc
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q;
    logic        kill_q;
    logic        mem_req_q;
    logic [15:0] mem_addr_q;
    logic [15:0] instr_q;
    logic [15:0] instr_pc_q;
    logic        instr_valid_q;
    logic [15:0] pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            kill_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC;
            instr_q       <= 16'h0000;
            instr_pc_q    <= 16'h0000;
            instr_valid_q <= 1'b0;
            pc_q          <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (branch_en) pc_q <= branch_addr;
                    if (enable) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= branch_en ? branch_addr : pc_q;
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    // A branch never withdraws the request; it marks the in-flight word stale.
                    if (branch_en) begin
                        pc_q   <= branch_addr;
                        kill_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (kill_q || branch_en) begin
                            kill_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            instr_q       <= mem_rdata;
                            instr_pc_q    <= mem_addr_q;
                            instr_valid_q <= 1'b1;
                            pc_q          <= mem_addr_q + 16'd1;
                            state_q       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (branch_en) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= branch_addr;
                        state_q       <= IDLE;
                    end else if (!stall) begin
                        instr_valid_q <= 1'b0;
                        if (enable) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc_q;
                            state_q    <= FETCH;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;

endmodule
